// File: rtl/sha256_state_acc.sv
// sha256_state_acc
//   Chaining-state accumulator for the SHA-256 miner datapath. It holds the
//   NUM_WORDS chaining words H and does the post-compression feed-forward
//   add, LANES words per beat. It also caches the first-block midstate (MID)
//   and produces the final digest, re-arming H to IV for the second hash.
//
// Ports
//   clk, rst          clock / asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only in IDLE
//   cmd               0 INIT, 1 ACCUM, 2 ACCUM_SAVE, 3 RESTORE, 4 FINAL
//   work_in           working variables a..h (word 0 in LSBs), captured at accept
//   state_out         current chaining state H
//   digest_out        last final digest
//   digest_valid      one-cycle pulse with done at the end of FINAL
//   mid_valid         midstate cache is valid
//   done              one-cycle pulse per completed legal command
//   err               one-cycle pulse on illegal cmd or RESTORE with empty cache
module sha256_state_acc #(
  parameter int NUM_WORDS = 8,
  parameter int WIDTH     = 32,
  parameter int LANES     = 2,
  parameter logic [NUM_WORDS*WIDTH-1:0] IV = {32'h5be0cd19, 32'h1f83d9ab,
    32'h9b05688c, 32'h510e527f, 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85,
    32'h6a09e667}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd,
  input  logic [NUM_WORDS*WIDTH-1:0] work_in,
  output logic [NUM_WORDS*WIDTH-1:0] state_out,
  output logic [NUM_WORDS*WIDTH-1:0] digest_out,
  output logic                       digest_valid,
  output logic                       mid_valid,
  output logic                       done,
  output logic                       err
);

  localparam int BEATS = NUM_WORDS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] C_INIT    = 3'd0;
  localparam logic [2:0] C_ACCUM   = 3'd1;
  localparam logic [2:0] C_SAVE    = 3'd2;
  localparam logic [2:0] C_RESTORE = 3'd3;
  localparam logic [2:0] C_FINAL   = 3'd4;

  logic [0:0]                 st;
  logic [BW-1:0]              b;
  logic [2:0]                 op;
  logic [NUM_WORDS*WIDTH-1:0] w_q, h_q, mid_q, dig_q;

  logic [LANES-1:0][WIDTH-1:0] lane_h, lane_w, lane_sum;

  // Steer the words of the current beat onto the LANES adders.
  always_comb begin
    lane_h = '0;
    lane_w = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (b == BW'(i / LANES)) begin
        lane_h[i % LANES] = h_q[i*WIDTH +: WIDTH];
        lane_w[i % LANES] = w_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-word modulo add; no carry crosses word boundaries.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_sum[l] = lane_h[l] + lane_w[l];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_IDLE;
      b            <= '0;
      op           <= C_INIT;
      w_q          <= '0;
      h_q          <= IV;
      mid_q        <= '0;
      dig_q        <= '0;
      mid_valid    <= 1'b0;
      digest_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      digest_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              C_INIT: begin
                h_q  <= IV;
                done <= 1'b1;
              end
              C_RESTORE: begin
                // An empty cache falls back to IV but still completes.
                if (mid_valid) h_q <= mid_q;
                else begin
                  h_q <= IV;
                  err <= 1'b1;
                end
                done <= 1'b1;
              end
              C_ACCUM, C_SAVE, C_FINAL: begin
                op  <= cmd;
                w_q <= work_in;
                b   <= '0;
                st  <= S_RUN;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        default: begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (b == BW'(i / LANES)) begin
              case (op)
                C_SAVE: begin
                  h_q[i*WIDTH +: WIDTH]   <= lane_sum[i % LANES];
                  mid_q[i*WIDTH +: WIDTH] <= lane_sum[i % LANES];
                end
                C_FINAL: begin
                  dig_q[i*WIDTH +: WIDTH] <= lane_sum[i % LANES];
                  h_q[i*WIDTH +: WIDTH]   <= IV[i*WIDTH +: WIDTH];
                end
                default: h_q[i*WIDTH +: WIDTH] <= lane_sum[i % LANES];
              endcase
            end
          end
          if (b == LAST_B) begin
            st   <= S_IDLE;
            done <= 1'b1;
            if (op == C_SAVE)  mid_valid    <= 1'b1;
            if (op == C_FINAL) digest_valid <= 1'b1;
          end else begin
            b <= b + 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd_ready  = (st == S_IDLE);
  assign state_out  = h_q;
  assign digest_out = dig_q;

endmodule

// File: tb/tb_sha256_state_acc.sv
module tb_sha256_state_acc;
  localparam int NW = 8;
  localparam logic [255:0] IVV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c,
    32'h510e527f, 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [255:0] work_in = '0;
  logic cmd_ready, digest_valid, mid_valid, done, err;
  logic [255:0] state_out, digest_out;

  int checks = 0, failures = 0;

  // Reference model: plain word arrays updated per whole command.
  logic [31:0] mh[NW], mmid[NW], mdig[NW];
  bit mmv;

  sha256_state_acc dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .work_in(work_in), .state_out(state_out),
    .digest_out(digest_out), .digest_valid(digest_valid),
    .mid_valid(mid_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ivw(input int i);
    return IVV[i*32 +: 32];
  endfunction

  function automatic logic [255:0] pack(input logic [31:0] a[NW]);
    logic [255:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = a[i];
    return v;
  endfunction

  function automatic logic [255:0] splat(input logic [31:0] x);
    logic [255:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = x;
    return v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      mh[i] = ivw(i); mmid[i] = '0; mdig[i] = '0;
    end
    mmv = 0;
  endtask

  // Returns the err the command should raise.
  task automatic model_cmd(input logic [2:0] c, input logic [255:0] w, output bit e);
    e = 0;
    case (c)
      3'd0: for (int i = 0; i < NW; i++) mh[i] = ivw(i);
      3'd1: for (int i = 0; i < NW; i++) mh[i] = mh[i] + w[i*32 +: 32];
      3'd2: begin
        for (int i = 0; i < NW; i++) begin
          mh[i] = mh[i] + w[i*32 +: 32]; mmid[i] = mh[i];
        end
        mmv = 1;
      end
      3'd3: begin
        if (mmv) mh = mmid;
        else begin
          for (int i = 0; i < NW; i++) mh[i] = ivw(i);
          e = 1;
        end
      end
      3'd4: for (int i = 0; i < NW; i++) begin
        mdig[i] = mh[i] + w[i*32 +: 32]; mh[i] = ivw(i);
      end
      default: e = 1;
    endcase
  endtask

  // Called at a negedge with the block idle; returns at the negedge after acceptance,
  // with work_in scrambled so a missing capture shows up.
  task automatic send(input logic [2:0] c, input logic [255:0] w);
    cmd_valid = 1'b1; cmd = c; work_in = w;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 3'($urandom_range(0, 7)); work_in = rnd256();
  endtask

  // lat counts cycles from the acceptance cycle up to and including the done cycle.
  task automatic wait_done(output int lat, output int rlow, output bit dv, output bit to);
    lat = 0; rlow = 0; dv = 0; to = 1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i + 1; dv = digest_valid; to = 0;
        break;
      end
      if (!cmd_ready) rlow++;
      // keep presenting a command during RUN; it must be ignored
      cmd_valid = 1'b1; cmd = 3'd0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state_out !== IVV || digest_out !== '0 || mid_valid !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || digest_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: state=%h dig=%h mv=%b done=%b err=%b dv=%b rdy=%b",
               state_out, digest_out, mid_valid, done, err, digest_valid, cmd_ready);
    end
  endtask

  task automatic test_init();
    bit e;
    send(3'd0, rnd256()); model_cmd(3'd0, '0, e);
    checks++;
    if (state_out[255:224] !== 32'h5be0cd19 || state_out !== pack(mh) ||
        done !== 1'b1 || cmd_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL init: state=%h done=%b rdy=%b err=%b", state_out, done, cmd_ready, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL init_done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_accum_wrap();
    int lat, rlow; bit dv, to, e;
    send(3'd1, splat(32'hFFFFFFFF)); model_cmd(3'd1, splat(32'hFFFFFFFF), e);
    wait_done(lat, rlow, dv, to);
    checks++;
    if (to || lat != 5 || rlow != 4) begin
      failures++; $display("FAIL accum_timing: lat=%0d rlow=%0d to=%b want 5/4/0", lat, rlow, to);
    end
    checks++;
    if (state_out[255:224] !== 32'h5be0cd18 || state_out[31:0] !== 32'h6a09e666 ||
        state_out !== pack(mh)) begin
      failures++; $display("FAIL accum_wrap: state=%h want %h", state_out, pack(mh));
    end
  endtask

  task automatic test_save_restore();
    int lat, rlow; bit dv, to, e;
    send(3'd0, '0); model_cmd(3'd0, '0, e);
    send(3'd2, splat(32'd1)); model_cmd(3'd2, splat(32'd1), e);
    wait_done(lat, rlow, dv, to);
    send(3'd1, splat(32'd5)); model_cmd(3'd1, splat(32'd5), e);
    wait_done(lat, rlow, dv, to);
    checks++;
    if (to || state_out !== pack(mh)) begin
      failures++; $display("FAIL accum_after_save: state=%h want %h", state_out, pack(mh));
    end
    send(3'd3, '0); model_cmd(3'd3, '0, e);
    checks++;
    if (state_out[255:224] !== 32'h5be0cd1a || state_out !== pack(mh) ||
        mid_valid !== 1'b1 || err !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL restore: state=%h mv=%b err=%b done=%b want %h", state_out,
               mid_valid, err, done, pack(mh));
    end
  endtask

  task automatic test_restore_empty();
    bit e;
    do_reset();
    send(3'd3, '0); model_cmd(3'd3, '0, e);
    checks++;
    if (err !== 1'b1 || state_out !== IVV || mid_valid !== 1'b0) begin
      failures++; $display("FAIL restore_empty: err=%b state=%h mv=%b", err, state_out, mid_valid);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL restore_empty_err_width: err=%b want 0", err);
    end
  endtask

  task automatic test_final();
    int lat, rlow; bit dv, to, e;
    send(3'd0, '0); model_cmd(3'd0, '0, e);
    send(3'd4, splat(32'd2)); model_cmd(3'd4, splat(32'd2), e);
    wait_done(lat, rlow, dv, to);
    checks++;
    if (to || dv !== 1'b1 || lat != 5 || digest_out[255:224] !== 32'h5be0cd1b ||
        digest_out !== pack(mdig)) begin
      failures++;
      $display("FAIL final: to=%b dv=%b lat=%0d dig=%h want %h", to, dv, lat, digest_out, pack(mdig));
    end
    checks++;
    if (state_out !== IVV) begin
      failures++; $display("FAIL final_rearm: state=%h want %h", state_out, IVV);
    end
    @(negedge clk);
    checks++;
    if (digest_valid !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL final_pulse_width: dv=%b done=%b want 0", digest_valid, done);
    end
  endtask

  task automatic test_rst_mid();
    int seen = 0; bit e;
    // Make sure MID and digest are non-zero so reset has something to clear.
    send(3'd2, rnd256()); repeat (4) @(negedge clk);
    send(3'd4, rnd256()); repeat (4) @(negedge clk);
    send(3'd1, rnd256());          // negedge after k
    @(negedge clk); @(negedge clk); // beats 0,1 written; beat 2 in progress
    rst = 1'b1;
    #1;
    checks++;
    if (state_out !== IVV || digest_out !== '0 || mid_valid !== 1'b0 ||
        cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: state=%h dig=%h mv=%b rdy=%b done=%b",
               state_out, digest_out, mid_valid, cmd_ready, done);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    for (int i = 0; i < 6; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || state_out !== IVV) begin
      failures++; $display("FAIL rst_mid_no_done: done_seen=%0d state=%h", seen, state_out);
    end
    e = 0;
  endtask

  task automatic test_illegal();
    logic [255:0] s0, d0; bit mv0;
    send(3'd2, rnd256()); repeat (4) @(negedge clk);
    s0 = state_out; d0 = digest_out; mv0 = mid_valid;
    send(3'd6, rnd256());
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || state_out !== s0 || digest_out !== d0 ||
        mid_valid !== mv0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL illegal: err=%b done=%b state=%h want %h", err, done, state_out, s0);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL illegal_width: err=%b done=%b", err, done);
    end
  endtask

  // Random back-to-back command stream against the model.
  task automatic test_back_to_back();
    int lat, rlow; bit dv, to, e;
    logic [2:0] c; logic [255:0] w;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      c = 3'($urandom_range(0, 7)); w = rnd256();
      send(c, w); model_cmd(c, w, e);
      if (c == 3'd1 || c == 3'd2 || c == 3'd4) begin
        wait_done(lat, rlow, dv, to);
        checks++;
        if (to || lat != 5 || dv !== (c == 3'd4)) begin
          failures++;
          $display("FAIL b2b_multi[%0d]: cmd=%0d to=%b lat=%0d dv=%b", n, c, to, lat, dv);
        end
      end else begin
        checks++;
        if (err !== e || done !== (c <= 3'd4)) begin
          failures++;
          $display("FAIL b2b_single[%0d]: cmd=%0d err=%b want %b done=%b", n, c, err, e, done);
        end
      end
      checks++;
      if (state_out !== pack(mh) || digest_out !== pack(mdig) || mid_valid !== mmv) begin
        failures++;
        $display("FAIL b2b_state[%0d]: cmd=%0d state=%h want %h dig=%h want %h mv=%b want %b",
                 n, c, state_out, pack(mh), digest_out, pack(mdig), mid_valid, mmv);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_accum_wrap();
    test_save_restore();
    test_restore_empty();
    test_final();
    test_rst_mid();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
